// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline stage chain: tag width,
// bubble encoding, legal depth range and stage-index clamping.
package pipe_pkg;

  localparam int RD_W      = 4;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 8;

  localparam logic            BUBBLE_VALID = 1'b0;
  localparam logic [RD_W-1:0] BUBBLE_RD    = '0;
  localparam logic            BUBBLE_WE    = 1'b0;

  // Stage indices past the oldest stage refer to the oldest stage.
  function automatic int clamp_stage(input int idx, input int depth);
    return (idx >= depth) ? depth - 1 : idx;
  endfunction

endpackage

// File: rtl/pipeline_stage_chain_if.sv
// Upstream/control/observation bundle of the pipeline stage chain.
// master = datapath/hazard side, slave = the chain itself.
interface pipeline_stage_chain_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) ();
  localparam int SW = $clog2(DEPTH);

  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic [RD_W-1:0]        in_rd;
  logic                   in_we;
  logic                   in_ready;
  logic                   stall;
  logic [SW-1:0]          stall_stage;
  logic                   flush;
  logic [SW-1:0]          flush_upto;
  logic [DEPTH-1:0]       stage_valid;
  logic [RD_W*DEPTH-1:0]  stage_rd;
  logic [DEPTH-1:0]       stage_we;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [RD_W-1:0]        out_rd;
  logic                   out_we;

  modport master (
    output in_valid, in_data, in_rd, in_we, stall, stall_stage, flush, flush_upto,
    input  in_ready, stage_valid, stage_rd, stage_we, out_valid, out_data, out_rd, out_we
  );

  modport slave (
    input  in_valid, in_data, in_rd, in_we, stall, stall_stage, flush, flush_upto,
    output in_ready, stage_valid, stage_rd, stage_we, out_valid, out_data, out_rd, out_we
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid, payload, destination tag and write enable.
// Select priority is bubble, then hold, then load.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_hold,
  input  logic             i_load,
  input  logic             i_bubble,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [RD_W-1:0]  i_rd,
  input  logic             i_we,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [RD_W-1:0]  o_rd,
  output logic             o_we
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [RD_W-1:0]  r_rd;
  logic             r_we;

  logic             w_valid_next;
  logic [WIDTH-1:0] w_data_next;
  logic [RD_W-1:0]  w_rd_next;
  logic             w_we_next;

  always_comb begin
    w_valid_next = r_valid;
    w_data_next  = r_data;
    w_rd_next    = r_rd;
    w_we_next    = r_we;
    if (i_bubble) begin
      w_valid_next = BUBBLE_VALID;
      w_data_next  = '0;
      w_rd_next    = BUBBLE_RD;
      w_we_next    = BUBBLE_WE;
    end else if (!i_hold && i_load) begin
      w_valid_next = i_valid;
      w_data_next  = i_data;
      w_rd_next    = i_rd;
      w_we_next    = i_we;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_valid <= BUBBLE_VALID;
      r_data  <= '0;
      r_rd    <= BUBBLE_RD;
      r_we    <= BUBBLE_WE;
    end else begin
      r_valid <= w_valid_next;
      r_data  <= w_data_next;
      r_rd    <= w_rd_next;
      r_we    <= w_we_next;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_rd    = r_rd;
  assign o_we    = r_we;

endmodule

// File: rtl/pipeline_stage_chain.sv
// DEPTH-stage register chain with hazard stall/bubble insertion, partial flush
// and per-stage tag visibility. PIPE_PERF_CNT_EN adds the bubble_cnt counter.
module pipeline_stage_chain
  import pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int SW    = $clog2(DEPTH)
) (
  input  logic Clk,
  input  logic Clr,
  pipeline_stage_chain_if.slave pipe
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0] bubble_cnt
`endif
);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("pipeline_stage_chain: DEPTH out of range");
  end

  logic [SW-1:0]         w_stall_idx;
  logic [DEPTH-1:0]      w_held;
  logic [DEPTH-1:0]      w_bubble;
  logic [DEPTH-1:0]      w_load;
  logic [DEPTH-1:0]      w_valid;
  logic [DEPTH-1:0]      w_we;
  logic [WIDTH-1:0]      w_data [DEPTH];
  logic [RD_W-1:0]       w_rd   [DEPTH];
  logic [DEPTH-1:0]      w_src_valid;
  logic [DEPTH-1:0]      w_src_we;
  logic [WIDTH-1:0]      w_src_data [DEPTH];
  logic [RD_W-1:0]       w_src_rd   [DEPTH];
  logic [RD_W*DEPTH-1:0] w_rd_flat;

  assign w_stall_idx   = SW'(clamp_stage(int'(pipe.stall_stage), DEPTH));
  assign pipe.in_ready = ~pipe.stall & ~pipe.flush;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    localparam logic [SW-1:0] IDX = SW'(gi);
    logic w_flushed;

    assign w_held[gi] = pipe.stall && (IDX <= w_stall_idx);
    assign w_flushed  = pipe.flush && (IDX <= pipe.flush_upto);

    if (gi == 0) begin : g_head
      assign w_bubble[gi]    = w_flushed || (!w_held[gi] && !pipe.in_valid);
      assign w_src_valid[gi] = pipe.in_valid;
      assign w_src_data[gi]  = pipe.in_data;
      assign w_src_rd[gi]    = pipe.in_rd;
      assign w_src_we[gi]    = pipe.in_we;
    end else begin : g_body
      // The first stage below a held region receives a bubble each stalled cycle.
      assign w_bubble[gi]    = w_flushed || (!w_held[gi] && w_held[gi-1]);
      assign w_src_valid[gi] = w_valid[gi-1];
      assign w_src_data[gi]  = w_data[gi-1];
      assign w_src_rd[gi]    = w_rd[gi-1];
      assign w_src_we[gi]    = w_we[gi-1];
    end

    assign w_load[gi] = !w_held[gi] && !w_bubble[gi];

    pipe_stage_reg #(.WIDTH(WIDTH)) u_stage (
      .clk      (Clk),
      .srst     (Clr),
      .i_hold   (w_held[gi]),
      .i_load   (w_load[gi]),
      .i_bubble (w_bubble[gi]),
      .i_valid  (w_src_valid[gi]),
      .i_data   (w_src_data[gi]),
      .i_rd     (w_src_rd[gi]),
      .i_we     (w_src_we[gi]),
      .o_valid  (w_valid[gi]),
      .o_data   (w_data[gi]),
      .o_rd     (w_rd[gi]),
      .o_we     (w_we[gi])
    );
  end

  always_comb begin
    w_rd_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rd_flat[i*RD_W +: RD_W] = w_rd[i];
    end
  end

  assign pipe.stage_valid = w_valid;
  assign pipe.stage_rd    = w_rd_flat;
  assign pipe.stage_we    = w_valid & w_we;
  assign pipe.out_valid   = w_valid[DEPTH-1];
  assign pipe.out_data    = w_data[DEPTH-1];
  assign pipe.out_rd      = w_rd[DEPTH-1];
  assign pipe.out_we      = w_valid[DEPTH-1] & w_we[DEPTH-1];

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] r_bubble_cnt;
  logic        w_out_valid_next;

  assign w_out_valid_next = w_bubble[DEPTH-1] ? 1'b0 :
                            w_held[DEPTH-1]   ? w_valid[DEPTH-1] :
                                                w_src_valid[DEPTH-1];

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_bubble_cnt <= '0;
    end else if (!w_out_valid_next && r_bubble_cnt != 16'hFFFF) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Scoreboard bench for pipeline_stage_chain (DEPTH=4, WIDTH=32): reset, latency,
// streaming, stall, flush, flush+stall and, with PIPE_PERF_CNT_EN, the counter.
module tb_pipeline_stage_chain;
  import pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef logic [WIDTH+RD_W:0] item_t;

  logic Clk = 1'b0;
  logic Clr = 1'b1;
  always #5 Clk = ~Clk;

  pipeline_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  pipeline_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk  (Clk),
    .Clr  (Clr),
    .pipe (bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  item_t sb[$];
  int    n_checks     = 0;
  int    n_errs       = 0;
  int    bubbles_seen = 0;
  int    squash_n     = 0;
  int    idx          = 0;
  int    b0           = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [3:0] rd, input logic we);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_rd    = rd;
    bus.in_we    = we;
  endtask

  task automatic drive_item(input int i);
    drive(1'b1, 32'h10 + WIDTH'(i), 4'(i), i[0]);
  endtask

  task automatic drain(input string tag);
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare retiring items, drop squashed ones, record accepted ones.
  always @(negedge Clk) begin
    item_t exp_item;
    if (!Clr) begin
      if (bus.out_valid) begin
        $display("out data=%h rd=%h we=%b", bus.out_data, bus.out_rd, bus.out_we);
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_item = sb.pop_front();
          check("out_item", 64'({bus.out_data, bus.out_rd, bus.out_we}), 64'(exp_item));
        end
      end else begin
        bubbles_seen++;
      end
      if (bus.flush) begin
        repeat (squash_n) if (sb.size() > 0) void'(sb.pop_back());
      end
      if (bus.in_valid && bus.in_ready) sb.push_back({bus.in_data, bus.in_rd, bus.in_we});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 32'h55, 4'h5, 1'b1);
    bus.stall       = 1'b0;
    bus.stall_stage = '0;
    bus.flush       = 1'b0;
    bus.flush_upto  = '0;

    // Reset
    tick();
    check("rst_stage_valid", 64'(bus.stage_valid), 64'd0);
    check("rst_out_valid",   64'(bus.out_valid),   64'd0);
    check("rst_out_data",    64'(bus.out_data),    64'd0);
    check("rst_stage_rd",    64'(bus.stage_rd),    64'd0);
    check("rst_stage_we",    64'(bus.stage_we),    64'd0);
    check("rst_in_ready",    64'(bus.in_ready),    64'd1);
`ifdef PIPE_PERF_CNT_EN
    check("rst_bubble_cnt",  64'(bubble_cnt),      64'd0);
`endif
    Clr = 1'b0;

    // Latency and streaming
    for (int k = 1; k <= 4; k++) begin
      drive_item(idx);
      idx++;
      tick();
      check("lat_out_valid", 64'(bus.out_valid), (k == 4) ? 64'd1 : 64'd0);
    end
    check("lat_out_data", 64'(bus.out_data), 64'h10);
    for (int k = 0; k < 6; k++) begin
      drive_item(idx);
      idx++;
      tick();
    end

    // Stall stages 0..1 for two cycles
    b0 = bubbles_seen;
    drive_item(idx);
    bus.stall = 1'b1;
    bus.stall_stage = 2'd1;
    #1;
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("stall1_valid", 64'(bus.stage_valid), 64'b1011);
    check("stall1_rd01", 64'(bus.stage_rd[7:0]), 64'({4'(idx - 2), 4'(idx - 1)}));
    tick();
    check("stall2_valid", 64'(bus.stage_valid), 64'b0011);
    check("stall2_rd01", 64'(bus.stage_rd[7:0]), 64'({4'(idx - 2), 4'(idx - 1)}));
    bus.stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_item(idx);
      idx++;
      tick();
    end
    check("stall_bubbles", 64'(bubbles_seen - b0), 64'd2);
    drain("drain_stream");

    // Flush stages 0..1 of a full pipe (A3 youngest)
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 32'hA0 + WIDTH'(j), 4'(j + 8), 1'b1);
      tick();
    end
    check("flush_pre_out", 64'(bus.out_data), 64'hA0);
    drive(1'b0, '0, '0, 1'b0);
    bus.flush = 1'b1;
    bus.flush_upto = 2'd1;
    squash_n = 1;
    tick();
    bus.flush = 1'b0;
    check("flush_valid", 64'(bus.stage_valid), 64'b1100);
    check("flush_we",    64'(bus.stage_we),    64'b1100);
    check("flush_rd23",  64'(bus.stage_rd[15:8]), 64'h9A);
    check("flush_out",   64'(bus.out_data),    64'hA1);
    drain("drain_flush");

    // Flush stage 0 while stalling stages 0..1
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 32'hB0 + WIDTH'(j), 4'(j + 4), j[0]);
      tick();
    end
    drive(1'b1, 32'hEE, 4'hE, 1'b1);
    bus.flush = 1'b1;
    bus.flush_upto = 2'd0;
    bus.stall = 1'b1;
    bus.stall_stage = 2'd1;
    squash_n = 1;
    #1;
    check("fs_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    check("fs_valid", 64'(bus.stage_valid), 64'b1010);
    check("fs_rd1",   64'(bus.stage_rd[7:4]), 64'd6);
    check("fs_we",    64'(bus.stage_we), 64'b1000);
    check("fs_out",   64'(bus.out_data), 64'hB1);
    drain("drain_fs");
    squash_n = 0;

`ifdef PIPE_PERF_CNT_EN
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    check("cnt_clr0", 64'(bubble_cnt), 64'd0);
    repeat (5) tick();
    check("cnt_5", 64'(bubble_cnt), 64'd5);
    repeat (70000) tick();
    check("cnt_sat", 64'(bubble_cnt), 64'hFFFF);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    check("cnt_clr1", 64'(bubble_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_chain.md
# pipeline_stage_chain

Parametrised chain of pipeline registers carrying a payload, a destination-register tag and a write-enable through DEPTH stages, each with a valid bit. It adds what fixed pipeline registers lack: hazard stall with bubble insertion, a branch flush of the younger stages, and per-stage tag visibility for hazard and forwarding logic. It sits between the fetch/decode/execute/memory/writeback datapath blocks of the ARM pipeline.

## Interface
Parameters:
- WIDTH, 32, payload bits per stage.
- DEPTH, 4, number of stages; legal range 2..8.
- SW, $clog2(DEPTH), width of stage-index inputs (derived).

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  clock, rising edge.
- Clr  in  1  synchronous active-high reset.
- in_valid  in  1  stage-0 input holds a real instruction.
- in_data  in  WIDTH  stage-0 payload.
- in_rd  in  4  destination register tag.
- in_we  in  1  register-file write enable of the instruction.
- in_ready  out  1  input accepted this cycle; equals !stall && !flush.
- stall  in  1  hazard stall request.
- stall_stage  in  SW  youngest-to-oldest index of the last stage held.
- flush  in  1  squash request.
- flush_upto  in  SW  stages 0..flush_upto are squashed.
- stage_valid  out  DEPTH  valid bit of each stage.
- stage_rd  out  4*DEPTH  tags; stage i is bits [4i+3:4i].
- stage_we  out  DEPTH  write enable of each stage, already ANDed with valid.
- out_valid, out_data, out_rd, out_we  out  1/WIDTH/4/1  contents of stage DEPTH-1.
- bubble_cnt  out  16  only when PIPE_PERF_CNT_EN is defined.

## Operation
- Stage 0 is the youngest stage and stage DEPTH-1 the oldest. A bubble is valid=0, data=0, rd=0, we=0.
- Clr: every stage becomes a bubble, and bubble_cnt resets to 0. Every output is 0 after reset; in_ready follows its inputs.
- stall_stage values of DEPTH or more are clamped to DEPTH-1.
- held(i) = stall && i <= stall_stage.
- Next state for stage i, evaluated in priority order:
  1. Clr: bubble.
  2. flush && i <= flush_upto: bubble.
  3. held(i): keep the current contents.
  4. i == 0: load the inputs if in_valid is 1; otherwise load a bubble.
  5. held(i-1): load a bubble (insertion point).
  6. Otherwise: take the contents of stage i-1.
- An instruction is accepted only when in_valid && in_ready. A rejected instruction must be re-presented by the upstream block.
- Flush takes priority over stall for the same stage. Stages that are held but lie above flush_upto keep their contents.
- stage_we[i] = stage_valid[i] & stored we. A bubble therefore never causes a register-file write.

## Timing
- Latency from an accepted input to out_* is DEPTH rising edges, with no stall.
- Throughput is one instruction per cycle.
- stall lasting N cycles with stall_stage=s:
  - stages 0..s are frozen for N cycles;
  - N bubbles enter stage s+1;
  - the older stages keep draining.
- stall_stage=DEPTH-1 freezes the entire chain, and out_* holds its value.
- flush takes effect at the next edge. The squashed stages read valid=0 in the following cycle.
- All outputs are registered except in_ready, which is combinational from stall and flush.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - bubble_cnt increments on every non-Clr edge where the next out_valid is 0;
  - it saturates at 16'hFFFF;
  - it is cleared by Clr.
- PIPE_PERF_CNT_EN undefined: the bubble_cnt port and its counter are absent.

## Structure
- Shared package pipe_pkg holds:
  - RD_W=4;
  - the bubble constants;
  - the DEPTH range limits;
  - a stage-index clamp function.
- One sub-module, pipe_stage_reg:
  - one stage holding valid, data, rd and we;
  - inputs for hold, load and bubble select;
  - instantiated DEPTH times in a generate loop.

## Test plan
Each scenario uses DEPTH=4 and WIDTH=32.
- Reset: assert Clr for 1 cycle with in_valid=1 -> stage_valid=0, out_valid=0, bubble_cnt=0. The first valid output appears 4 edges after Clr deasserts.
- Streaming: present data 0x10,0x11,0x12,... every cycle -> out_data=0x10 on the 4th edge, then consecutive values every cycle, out_valid=1 throughout.
- Stall: stall=1 with stall_stage=1 for 2 cycles while streaming -> in_ready=0, stages 0 and 1 hold, out_valid sequence shows 2 bubbles, no payload is lost or duplicated.
- Flush: flush=1 with flush_upto=1 for one edge while stages hold 0xA0..0xA3 -> stages 0 and 1 become invalid, 0xA1 and 0xA0 exit normally, stage_we is 0 for the squashed slots.
- Flush and stall together: flush=1 with flush_upto=0, plus stall=1 with stall_stage=1 -> stage 0 becomes a bubble, stage 1 holds, stage 2 receives a bubble.
- Counter with PIPE_PERF_CNT_EN defined: leave in_valid=0 for 70000 cycles -> bubble_cnt saturates at 0xFFFF. A following Clr returns it to 0.
